// File: rtl/lif_array.sv
// Multi-channel leaky integrate-and-fire neuron array with shift leak, saturating integration,
// shared threshold and refractory hold-off. Optional per-channel spike counters: LIF_SPIKE_COUNT_EN.
module lif_array #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned LEAK_SHIFT = 2,
   parameter int unsigned REFRACT    = 3,
   localparam int unsigned CW        = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [WIDTH-1:0]    current,
   input  logic [CW-1:0]       current_ch,
   input  logic                current_valid,
   input  logic [WIDTH-1:0]    threshold,
   input  logic [CW-1:0]       rd_ch,
   output logic [WIDTH-1:0]    state,
   output logic [CHANNELS-1:0] spike,
   output logic [CHANNELS-1:0] refractory
`ifdef LIF_SPIKE_COUNT_EN
   ,
   input  logic                clear_counts,
   output logic [7:0]          spike_count
`endif
);

   // Keep the hold-off counter at least one bit wide so REFRACT == 0 still elaborates.
   localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   logic [WIDTH-1:0]    v_q   [CHANNELS];
   logic [WIDTH-1:0]    v_d   [CHANNELS];
   logic [WIDTH-1:0]    n_sat [CHANNELS];
   logic [RW-1:0]       r_q   [CHANNELS];
   logic [RW-1:0]       r_d   [CHANNELS];
   logic [CHANNELS-1:0] fire;
   logic [CHANNELS-1:0] spike_q;
   logic [CHANNELS-1:0] spike_d;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic             hit;
      logic [WIDTH-1:0] inj;
      logic [WIDTH-1:0] leak;
      logic [WIDTH:0]   sum;

      // Out-of-range current_ch never matches any channel, so the input is dropped.
      assign hit  = current_valid && (current_ch == CW'(g));
      assign inj  = hit ? current : '0;
      assign leak = v_q[g] >> LEAK_SHIFT;
      assign sum  = {1'b0, v_q[g]} - {1'b0, leak} + {1'b0, inj};
      assign n_sat[g] = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      assign fire[g]  = (n_sat[g] >= threshold);
      assign refractory[g] = (r_q[g] != '0);
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         v_d[i]     = v_q[i];
         r_d[i]     = r_q[i];
         spike_d[i] = 1'b0;
         if (en) begin
            if (r_q[i] != '0) begin
               v_d[i] = '0;
               r_d[i] = r_q[i] - 1'b1;
            end else if (fire[i]) begin
               v_d[i]     = '0;
               r_d[i]     = RW'(REFRACT);
               spike_d[i] = 1'b1;
            end else begin
               v_d[i] = n_sat[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            v_q[i] <= '0;
            r_q[i] <= '0;
         end
         spike_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            v_q[i] <= v_d[i];
            r_q[i] <= r_d[i];
         end
         spike_q <= spike_d;
      end
   end

   assign spike = spike_q;

   if (CHANNELS == (1 << CW)) begin : g_rd_full
      assign state = v_q[rd_ch];
   end else begin : g_rd_part
      assign state = (rd_ch < CW'(CHANNELS)) ? v_q[rd_ch] : '0;
   end

`ifdef LIF_SPIKE_COUNT_EN
   logic [7:0] cnt_q [CHANNELS];
   logic [7:0] cnt_d [CHANNELS];

   // Clear beats a coincident fire; counts saturate at 255.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear_counts) begin
            cnt_d[i] = '0;
         end else if (spike_d[i] && (cnt_q[i] != 8'hff)) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   if (CHANNELS == (1 << CW)) begin : g_cnt_full
      assign spike_count = cnt_q[rd_ch];
   end else begin : g_cnt_part
      assign spike_count = (rd_ch < CW'(CHANNELS)) ? cnt_q[rd_ch] : '0;
   end
`endif

endmodule
